// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: issues one word read at a time and queues {pc, instr} for decode.
// Optional misaligned-redirect fault: define IF_MISALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | one request outstanding, waiting for imem_rvalid
// DROP  | request outstanding but made stale by a redirect; its response is discarded
module if_prefetch_stage #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [63:0] id_pc
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state;
    logic [63:0]   next_pc;
    logic [63:0]   req_pc;
    logic [31:0]   q_instr [QUEUE_DEPTH];
    logic [63:0]   q_pc    [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          issue;
    logic          has_space;
    logic          fault;
    logic [63:0]   redirect_target;

`ifdef IF_MISALIGN_CHECK_EN
    logic fault_q;
    assign fault           = fault_q;
    assign fetch_fault     = fault_q;
    assign redirect_target = redirect_pc;
`else
    assign fault           = 1'b0;
    assign redirect_target = redirect_pc & ~64'h3;
`endif

    // Space check deliberately ignores a same-cycle pop.
    assign push      = (state == WAIT) && imem_rvalid && !redirect_valid;
    assign pop       = id_valid && id_ready && !redirect_valid;
    assign has_space = (count + CW'(push)) < CW'(QUEUE_DEPTH);
    assign issue     = !reset && !redirect_valid && !fault && has_space &&
                       ((state == IDLE) || ((state == WAIT) && imem_rvalid));

    assign imem_req       = issue;
    assign imem_addr      = next_pc;
    assign id_valid       = (count != '0);
    assign id_instruction = q_instr[rd_ptr];
    assign id_pc          = q_pc[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            next_pc <= RESET_PC;
            req_pc  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
`ifdef IF_MISALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else if (redirect_valid) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            next_pc <= redirect_target;
`ifdef IF_MISALIGN_CHECK_EN
            fault_q <= |redirect_pc[1:0];
`endif
            if (state == WAIT) begin
                state <= imem_rvalid ? IDLE : DROP;
            end
        end else begin
            if (issue) begin
                req_pc  <= next_pc;
                next_pc <= next_pc + 64'd4;
            end
            if (push) begin
                q_instr[wr_ptr] <= imem_rdata;
                q_pc[wr_ptr]    <= req_pc;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            case (state)
                IDLE: if (issue) state <= WAIT;
                WAIT: if (imem_rvalid) state <= issue ? WAIT : IDLE;
                DROP: if (imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: cycle table for backpressure plus hand sequences for redirects.
`timescale 1ns/1ps
module tb_if_prefetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [63:0] id_pc;
`ifdef IF_MISALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    if_prefetch_stage #(.RESET_PC(64'd0), .QUEUE_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instruction (id_instruction),
        .id_pc          (id_pc)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          due   = 0;
    int          lat   = 1;
    bit          pend  = 0;
    bit          const_data = 0;
    logic [63:0] paddr = '0;

    typedef struct {
        bit          rdy;
        bit          req;
        logic [63:0] addr;
        bit          vld;
        logic [63:0] pc;
        logic [31:0] ins;
    } vec_t;

    vec_t bp [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: data is pc+0x13 (or constant 0x13), response lat cycles after the request.
    task automatic tick();
        if (!reset && imem_req) begin
            pend  = 1;
            due   = cyc + lat;
            paddr = imem_addr;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (reset) pend = 0;
        if (pend && due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = const_data ? 32'h13 : paddr[31:0] + 32'h13;
            pend        = 0;
        end else begin
            imem_rvalid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        pend           = 0;
        tick();
        tick();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", id_valid, 0);
        reset = 1'b0;
        cyc   = 0;
        #1;
    endtask

    initial begin
        bit seen;

        // cycle-by-cycle expectations, depth 4, L=1
        bp[0] = '{0, 1, 64'h00, 0, 64'h0, 32'h0};
        bp[1] = '{0, 1, 64'h04, 0, 64'h0, 32'h0};
        bp[2] = '{0, 1, 64'h08, 1, 64'h0, 32'h13};
        bp[3] = '{0, 1, 64'h0c, 1, 64'h0, 32'h13};
        bp[4] = '{0, 0, 64'h10, 1, 64'h0, 32'h13};
        bp[5] = '{0, 0, 64'h10, 1, 64'h0, 32'h13};
        bp[6] = '{1, 0, 64'h10, 1, 64'h0, 32'h13};
        bp[7] = '{0, 1, 64'h10, 1, 64'h4, 32'h17};
        bp[8] = '{0, 0, 64'h14, 1, 64'h4, 32'h17};
        bp[9] = '{0, 0, 64'h14, 1, 64'h4, 32'h17};

        // backpressure table
        lat = 1;
        const_data = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            id_ready = bp[i].rdy;
            #1;
            chk($sformatf("bp_req[%0d]", i), imem_req, bp[i].req);
            chk($sformatf("bp_addr[%0d]", i), imem_addr, bp[i].addr);
            chk($sformatf("bp_valid[%0d]", i), id_valid, bp[i].vld);
            if (bp[i].vld) begin
                chk($sformatf("bp_pc[%0d]", i), id_pc, bp[i].pc);
                chk($sformatf("bp_ins[%0d]", i), id_instruction, bp[i].ins);
            end
            tick();
        end

        // first fetch and sustained push+pop at count=2 with pointer wrap
        const_data = 1;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            id_ready = (c >= 3);
            #1;
            chk($sformatf("ff_req[%0d]", c), imem_req, 1);
            chk($sformatf("ff_addr[%0d]", c), imem_addr, 64'(4 * c));
            if (c >= 2) begin
                chk($sformatf("ff_valid[%0d]", c), id_valid, 1);
                chk($sformatf("ff_pc[%0d]", c), id_pc, (c <= 3) ? 64'd0 : 64'(4 * (c - 3)));
                chk($sformatf("ff_ins[%0d]", c), id_instruction, 32'h13);
            end
            tick();
        end

        // redirect while waiting, L=3
        const_data = 0;
        lat = 3;
        do_reset();
        id_ready = 1'b1;
        #1;
        chk("rw_req0", imem_req, 1);
        chk("rw_addr0", imem_addr, 64'h0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        #1;
        chk("rw_redir_noreq", imem_req, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rw_drop_noreq", imem_req, 0);
        chk("rw_drop_valid", id_valid, 0);
        tick();
        chk("rw_stale_noreq", imem_req, 0);
        tick();
        chk("rw_req_new", imem_req, 1);
        chk("rw_addr_new", imem_addr, 64'h100);
        tick();
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (id_valid) seen = 1;
            else tick();
        end
        chk("rw_valid_timeout", seen, 1);
        chk("rw_pc", id_pc, 64'h100);
        chk("rw_ins", id_instruction, 32'h113);

        // redirect coincident with response, L=2
        lat = 2;
        do_reset();
        #1;
        chk("rc_addr0", imem_addr, 64'h0);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        #1;
        chk("rc_noreq", imem_req, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rc_empty", id_valid, 0);
        chk("rc_req", imem_req, 1);
        chk("rc_addr", imem_addr, 64'h200);
        tick();
        tick();
        chk("rc_req2", imem_req, 1);
        chk("rc_addr2", imem_addr, 64'h204);
        tick();
        chk("rc_valid", id_valid, 1);
        chk("rc_pc", id_pc, 64'h200);
        chk("rc_ins", id_instruction, 32'h213);

        // misaligned redirect while a request is outstanding
        redirect_valid = 1'b1;
        redirect_pc    = 64'h102;
        #1;
        chk("ma_noreq", imem_req, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("ma_flushed", id_valid, 0);
        chk("ma_stale_noreq", imem_req, 0);
`ifdef IF_MISALIGN_CHECK_EN
        chk("ma_fault", fetch_fault, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("ma_hold_req[%0d]", k), imem_req, 0);
            chk($sformatf("ma_hold_fault[%0d]", k), fetch_fault, 1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h104;
        #1;
        chk("ma_clr_noreq", imem_req, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("ma_fault_clr", fetch_fault, 0);
        chk("ma_resume_req", imem_req, 1);
        chk("ma_resume_addr", imem_addr, 64'h104);
`else
        tick();
        chk("ma_resume_req", imem_req, 1);
        chk("ma_resume_addr", imem_addr, 64'h100);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Instruction-fetch front end for the 5-stage RISC-V pipeline. It owns the fetch PC, issues word reads to instruction memory over a request/response handshake, and buffers returned instructions with their PCs in a small queue. The decode stage (IF_ID register) drains the queue with a valid/ready handshake. Branch redirects from EX flush all in-flight work.

## Interface
- `RESET_PC`, default `64'd0`: fetch PC loaded on reset.
- `QUEUE_DEPTH`, default `4`: number of queue entries; a power of two from 2 to 8.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `imem_req`  out  1  one-cycle request pulse; the address is accepted in the same cycle.
- `imem_addr`  out  64  byte address of the request; equals `next_pc`.
- `imem_rvalid`  in  1  response strobe, arriving at least 1 cycle after its request.
- `imem_rdata`  in  32  instruction word; valid when `imem_rvalid` is high.
- `redirect_valid`  in  1  taken branch or jump from EX (`Branch & zero`).
- `redirect_pc`  in  64  target PC for the redirect.
- `id_valid`  out  1  queue head is valid.
- `id_ready`  in  1  decode accepts the queue head.
- `id_instruction`  out  32  instruction at the queue head.
- `id_pc`  out  64  PC of the instruction at the queue head.
- `fetch_fault`  out  1  misaligned-redirect flag. Present only when `IF_MISALIGN_CHECK_EN` is defined.

## Operation
- **State:**
  - `next_pc`: address of the next request.
  - `req_pc`: address of the outstanding request.
  - Queue storage, plus `wr_ptr`, `rd_ptr`, `count`.
  - FSM `{IDLE, WAIT, DROP}`.
- **Request:** at most one request is outstanding at a time.
  - `imem_req` = `!redirect_valid && (IDLE || (WAIT && imem_rvalid)) && (count + push) < QUEUE_DEPTH`.
  - `push` = `WAIT && imem_rvalid && !redirect_valid`.
  - A pop in the same cycle is not credited when computing space.
- **On issue:** `req_pc <= next_pc`, `next_pc <= next_pc + 4` (64-bit wrap), FSM → WAIT.
- **WAIT, `imem_rvalid` high:**
  - Push `{req_pc, imem_rdata}` at `wr_ptr`.
  - If a new request is issued in the same cycle, stay in WAIT; otherwise go to IDLE.
- **Pop:** occurs when `id_valid && id_ready` and there is no redirect; `rd_ptr` increments.
  - Push and pop in the same cycle leave `count` unchanged.
  - Pointers wrap modulo `QUEUE_DEPTH`.
- **Outputs:**
  - `id_valid = (count != 0)`.
  - `id_instruction` and `id_pc` are driven combinationally from the registered head entry.
- **Redirect (highest priority):**
  - Queue flushed: `count`, `wr_ptr` and `rd_ptr` all go to 0.
  - `next_pc <= redirect_pc`.
  - No push, pop or request occurs that cycle.
  - FSM transitions:
    - IDLE → IDLE.
    - WAIT with `imem_rvalid` high: response discarded, → IDLE.
    - WAIT with `imem_rvalid` low: → DROP.
    - DROP → DROP.
- **DROP:** no requests are issued. The next `imem_rvalid` is discarded and the FSM returns to IDLE.
- **Reset:**
  - `next_pc = RESET_PC`, `req_pc = 0`.
  - Queue empty, FSM IDLE.
  - `id_valid = 0`, `imem_req = 0` while `reset` is high.
  - `fetch_fault = 0`.
  - A reset during WAIT or DROP abandons the outstanding response. The memory model must not return a response after reset.

## Timing
- **First request:** `imem_req` is high in the first cycle after `reset` deasserts, with `imem_addr = RESET_PC`.
- **Fetch latency:** with a memory returning `imem_rvalid` L cycles after the request, the instruction reaches `id_valid` 1 cycle after the `imem_rvalid` cycle.
- **Throughput:** with L = 1 and the queue not near full, one request per cycle is sustained (back-to-back through WAIT).
- **Full queue:** no request is issued once `count + push == QUEUE_DEPTH`. Issue resumes the cycle after a pop frees space.
- **Empty queue with pop:** `id_ready` while `id_valid` is low has no effect.
- **Redirect turnaround:**
  - From IDLE: the request to `redirect_pc` is issued the cycle after the redirect.
  - From DROP: the request is issued the cycle after the stale response.

## Configuration
- **`IF_MISALIGN_CHECK_EN` defined:**
  - A redirect with `redirect_pc[1:0] != 0` still flushes and loads `next_pc`.
  - It also sets `fetch_fault`, which is sticky.
  - While `fetch_fault` is high, `imem_req` is held low.
  - A later aligned redirect clears `fetch_fault` and fetch resumes.
- **Not defined:**
  - The `fetch_fault` port is absent.
  - `redirect_pc[1:0]` is ignored; `next_pc` loads `{redirect_pc[63:2], 2'b00}`.

## Test plan
- **Reset and first fetch:** `RESET_PC=0`, memory L=1 returning `0x00000013`, `id_ready=1` → requests to 0x0, 0x4, 0x8 on consecutive cycles. `id_pc` follows the sequence 0x0, 0x4, 0x8, and `id_instruction=0x00000013`.
- **Backpressure:** `id_ready=0`, depth 4 → exactly 4 requests, then `imem_req` stays low. Raising `id_ready` for one cycle pops PC 0x0, and the next request (0x10) issues the following cycle.
- **Redirect while waiting:** memory L=3, `redirect_pc=0x100` 1 cycle after the request → FSM enters DROP. The stale response is discarded, the next request has `imem_addr=0x100`, and the first `id_pc` after the redirect is 0x100.
- **Redirect coincident with response:** `redirect_pc=0x200` in the same cycle as `imem_rvalid` → no push, queue empty, next request to 0x200.
- **Simultaneous push and pop at `count=2`:** `count` stays at 2 and pointers advance. Exercise pointer wrap over 8+ instructions; `id_pc` must be strictly sequential.
- **Misaligned redirect:** `redirect_pc=0x102`.
  - With the macro: `fetch_fault=1`, no requests; then `redirect_pc=0x104` clears it and fetch resumes at 0x104.
  - Without the macro: fetch resumes at 0x100.
